// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and defaults for the cache-line to memory-burst adaptor.
// Sits alongside the rv32i_types package in the same slice.
package cacheline_adaptor_pkg;

    localparam int unsigned DEFAULT_LINE_WIDTH  = 256;
    localparam int unsigned DEFAULT_BURST_WIDTH = 64;
    localparam int unsigned DEFAULT_ADDR_WIDTH  = 32;
    localparam int unsigned DEFAULT_BEATS       = DEFAULT_LINE_WIDTH / DEFAULT_BURST_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } adaptor_state_t;

    // Beat counter width; kept at least one bit so a single-beat line still elaborates.
    function automatic int unsigned beat_cnt_width(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/line_shift_reg.sv
// Line-wide register viewed as BEATS slices of BURST_WIDTH bits.
// Supports a full-line load or a single-slice write, plus a slice select,
// all indexed by the adaptor's beat counter.
module line_shift_reg #(
    parameter int unsigned LINE_WIDTH  = 256,
    parameter int unsigned BURST_WIDTH = 64,
    parameter int unsigned CNT_W       = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [LINE_WIDTH-1:0]  line_in,
    input  logic                   beat_we,
    input  logic [BURST_WIDTH-1:0] beat_in,
    input  logic [CNT_W-1:0]       beat_idx,
    output logic [LINE_WIDTH-1:0]  line_out,
    output logic [BURST_WIDTH-1:0] beat_out
);

    localparam int unsigned BEATS = LINE_WIDTH / BURST_WIDTH;

    logic [BEATS-1:0][BURST_WIDTH-1:0] line_q;

    // Full-line load takes priority over a slice write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= '0;
        end else if (load) begin
            line_q <= line_in;
        end else if (beat_we) begin
            line_q[beat_idx] <= beat_in;
        end
    end

    assign line_out = line_q;
    assign beat_out = line_q[beat_idx];

endmodule

// File: rtl/cacheline_adaptor.sv
// Cache-line adaptor: turns one whole-line read/write from the L1 cache into
// a BEATS-long burst on the narrow memory bus, and returns a one-cycle resp_o.
// Optional feature macro: ADAPTOR_PERF_CNT_EN (line read/write completion counters).
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
#(
    parameter int unsigned LINE_WIDTH  = DEFAULT_LINE_WIDTH,
    parameter int unsigned BURST_WIDTH = DEFAULT_BURST_WIDTH,
    parameter int unsigned ADDR_WIDTH  = DEFAULT_ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    input  logic [ADDR_WIDTH-1:0]  address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    output logic                   resp_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    output logic [ADDR_WIDTH-1:0]  address_o,
    output logic                   read_o,
    output logic                   write_o,
    input  logic                   resp_i,
    output logic [31:0]            perf_reads,
    output logic [31:0]            perf_writes
);

    localparam int unsigned BEATS    = LINE_WIDTH / BURST_WIDTH;
    localparam int unsigned CNT_W    = beat_cnt_width(BEATS);
    localparam int unsigned OFFSET_W = $clog2(LINE_WIDTH / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    adaptor_state_t        state_q;
    logic [CNT_W-1:0]      count_q;
    logic [ADDR_WIDTH-1:0] address_q;
    logic                  read_q;
    logic                  write_q;
    logic                  resp_q;

    logic [ADDR_WIDTH-1:0] line_addr;
    logic                  rd_beat_we;
    logic                  wr_load;
    logic [BURST_WIDTH-1:0] unused_rd_beat;
    logic [LINE_WIDTH-1:0]  unused_wr_line;
    logic                   unused_addr_bits;

    // Line-aligned address: the byte offset within the line is dropped.
    assign line_addr        = {address_i[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
    assign unused_addr_bits = ^address_i[OFFSET_W-1:0];

    assign rd_beat_we = (state_q == RD_BURST) && resp_i;
    // Read wins a simultaneous request, so only a lone write loads the line.
    assign wr_load    = (state_q == IDLE) && !read_i && write_i;

    // Request/burst FSM with registered memory-side and cache-side strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            address_q <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            resp_q    <= 1'b0;
        end else begin
            resp_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (read_i) begin
                        address_q <= line_addr;
                        read_q    <= 1'b1;
                        state_q   <= RD_BURST;
                    end else if (write_i) begin
                        address_q <= line_addr;
                        write_q   <= 1'b1;
                        state_q   <= WR_BURST;
                    end
                end
                RD_BURST: begin
                    if (resp_i) begin
                        count_q <= count_q + 1'b1;
                        if (count_q == LAST_BEAT) begin
                            read_q  <= 1'b0;
                            resp_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                WR_BURST: begin
                    if (resp_i) begin
                        count_q <= count_q + 1'b1;
                        if (count_q == LAST_BEAT) begin
                            write_q <= 1'b0;
                            resp_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Requests still held here are ignored; the cache drops them on resp_o.
                    count_q <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read assembly buffer; only a read ever changes it, so line_o holds across writes.
    line_shift_reg #(
        .LINE_WIDTH (LINE_WIDTH),
        .BURST_WIDTH(BURST_WIDTH),
        .CNT_W      (CNT_W)
    ) u_rd_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (1'b0),
        .line_in ({LINE_WIDTH{1'b0}}),
        .beat_we (rd_beat_we),
        .beat_in (burst_i),
        .beat_idx(count_q),
        .line_out(line_o),
        .beat_out(unused_rd_beat)
    );

    // Write slicing buffer; latched once in IDLE, then read out beat by beat.
    line_shift_reg #(
        .LINE_WIDTH (LINE_WIDTH),
        .BURST_WIDTH(BURST_WIDTH),
        .CNT_W      (CNT_W)
    ) u_wr_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (wr_load),
        .line_in (line_i),
        .beat_we (1'b0),
        .beat_in ({BURST_WIDTH{1'b0}}),
        .beat_idx(count_q),
        .line_out(unused_wr_line),
        .beat_out(burst_o)
    );

    assign address_o = address_q;
    assign read_o    = read_q;
    assign write_o   = write_q;
    assign resp_o    = resp_q;

`ifdef ADAPTOR_PERF_CNT_EN
    logic        txn_write_q;
    logic [31:0] perf_reads_q;
    logic [31:0] perf_writes_q;

    // Completion counters, bumped once per DONE according to the accepted request type.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_write_q   <= 1'b0;
            perf_reads_q  <= '0;
            perf_writes_q <= '0;
        end else begin
            if (state_q == IDLE && (read_i || write_i)) begin
                txn_write_q <= !read_i;
            end
            if (state_q == DONE) begin
                if (txn_write_q) begin
                    perf_writes_q <= perf_writes_q + 32'd1;
                end else begin
                    perf_reads_q <= perf_reads_q + 32'd1;
                end
            end
        end
    end

    assign perf_reads  = perf_reads_q;
    assign perf_writes = perf_writes_q;
`else
    assign perf_reads  = '0;
    assign perf_writes = '0;
`endif

    // A simultaneous read and write in IDLE must always start a read burst.
    read_wins_a: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == IDLE && read_i && write_i) |=> (state_q == RD_BURST));

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: drivers push expected line
// responses and write beats; a monitor pops and compares on resp_o / beats.
module tb_cacheline_adaptor;

    localparam int unsigned LW    = 256;
    localparam int unsigned BW    = 64;
    localparam int unsigned AW    = 32;
    localparam int unsigned BEATS = LW / BW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [LW-1:0] line_i;
    logic [LW-1:0] line_o;
    logic [AW-1:0] address_i;
    logic          read_i;
    logic          write_i;
    logic          resp_o;
    logic [BW-1:0] burst_i;
    logic [BW-1:0] burst_o;
    logic [AW-1:0] address_o;
    logic          read_o;
    logic          write_o;
    logic          resp_i;
    logic [31:0]   perf_reads;
    logic [31:0]   perf_writes;

    cacheline_adaptor #(
        .LINE_WIDTH (LW),
        .BURST_WIDTH(BW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .line_i     (line_i),
        .line_o     (line_o),
        .address_i  (address_i),
        .read_i     (read_i),
        .write_i    (write_i),
        .resp_o     (resp_o),
        .burst_i    (burst_i),
        .burst_o    (burst_o),
        .address_o  (address_o),
        .read_o     (read_o),
        .write_o    (write_o),
        .resp_i     (resp_i),
        .perf_reads (perf_reads),
        .perf_writes(perf_writes)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_write;
        logic [LW-1:0] line;
        int unsigned   req_cyc;
        int            exp_lat;
    } txn_t;

    txn_t          exp_q[$];
    logic [BW-1:0] mem_q[$];
    logic [BW-1:0] wr_q[$];

    int            n_checks = 0;
    int            n_fail = 0;
    int            model_reads = 0;
    int            model_writes = 0;
    int unsigned   cyc = 0;
    logic [AW-1:0] cur_addr = '0;
    bit            use_pattern = 1'b0;
    logic [31:0]   resp_pattern = '0;
    int            gap_pct = 0;
    int            bcyc = 0;
    bit            go;
    txn_t          mon_t;
    logic [BW-1:0] mon_b;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Memory model: answers beats with random or patterned gaps, noise when idle.
    initial begin
        resp_i  = 1'b0;
        burst_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && (read_o || write_o)) begin
                if (use_pattern) go = (bcyc < 32) ? resp_pattern[bcyc] : 1'b1;
                else go = ($urandom_range(99) >= gap_pct);
                bcyc++;
                resp_i = go;
                if (read_o && go && mem_q.size() > 0) burst_i = mem_q.pop_front();
                else burst_i = {$urandom, $urandom};
            end else begin
                bcyc    = 0;
                resp_i  = 1'($urandom_range(1));
                burst_i = {$urandom, $urandom};
            end
        end
    end

    // Monitor: compares write beats, addresses and line responses against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("rd_wr_exclusive", LW'(read_o & write_o), '0);
                if ((read_o || write_o) && resp_i)
                    check("address_o", LW'(address_o), LW'(cur_addr));
                if (write_o && resp_i) begin
                    if (wr_q.size() == 0) begin
                        flag("extra_write_beat", $sformatf("burst_o=%h with no beat due", burst_o));
                    end else begin
                        mon_b = wr_q.pop_front();
                        check("burst_o", LW'(burst_o), LW'(mon_b));
                    end
                end
                if (resp_o) begin
                    if (exp_q.size() == 0) begin
                        flag("unexpected_resp", "resp_o=1 with no transaction outstanding");
                    end else begin
                        mon_t = exp_q.pop_front();
                        if (mon_t.is_write) begin
                            model_writes++;
                            check("write_beats_left", LW'(wr_q.size()), '0);
                        end else begin
                            model_reads++;
                            check("line_o", line_o, mon_t.line);
                        end
                        if (mon_t.exp_lat > 0)
                            check("latency", LW'(cyc - mon_t.req_cyc + 1), LW'(mon_t.exp_lat));
                    end
                end
            end
        end
    end

    task automatic run_txn(input bit rd, input bit wr, input logic [AW-1:0] addr,
                           input logic [LW-1:0] wline, input logic [BW-1:0] beats [BEATS],
                           input int exp_lat);
        txn_t          t;
        logic [LW-1:0] rline = '0;
        logic [LW-1:0] junk;
        int            w = 0;
        @(negedge clk);
        cur_addr = addr & ~32'h1F;
        if (rd) begin
            for (int i = 0; i < BEATS; i++) begin
                mem_q.push_back(beats[i]);
                rline |= LW'(beats[i]) << (i * BW);
            end
        end else begin
            for (int i = 0; i < BEATS; i++) wr_q.push_back(wline[i*BW +: BW]);
        end
        t.is_write = !rd;
        t.line     = rline;
        t.req_cyc  = cyc;
        t.exp_lat  = exp_lat;
        exp_q.push_back(t);
        read_i    = rd;
        write_i   = wr;
        address_i = addr;
        line_i    = wline;
        @(negedge clk);
        // Scramble inputs after the latch edge; they must have no effect.
        for (int i = 0; i < 8; i++) junk[i*32 +: 32] = $urandom;
        address_i = $urandom;
        line_i    = junk;
        while (!resp_o && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!resp_o) begin
            flag("resp_timeout", $sformatf("no resp_o within %0d cycles", w));
            exp_q.delete();
            mem_q.delete();
            wr_q.delete();
        end
        read_i  = 1'b0;
        write_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [BW-1:0] bt [BEATS];
    logic [LW-1:0] wl;
    logic [LW-1:0] exp1;
    bit            rd_sel;

    initial begin
        rst_n     = 1'b0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        address_i = '0;
        line_i    = '0;
        repeat (2) @(negedge clk);
        check("rst_line_o", line_o, '0);
        check("rst_burst_o", LW'(burst_o), '0);
        check("rst_address_o", LW'(address_o), '0);
        check("rst_strobes", LW'({read_o, write_o, resp_o}), '0);
        check("rst_perf", LW'({perf_reads, perf_writes}), '0);
        rst_n = 1'b1;

        // Back-to-back read of four distinct beats.
        bt[0] = 64'h1111_1111_1111_1111;
        bt[1] = 64'h2222_2222_2222_2222;
        bt[2] = 64'h3333_3333_3333_3333;
        bt[3] = 64'h4444_4444_4444_4444;
        exp1 = {bt[3], bt[2], bt[1], bt[0]};
        run_txn(1'b1, 1'b0, 32'h0000_1234, '0, bt, 6);
        check("t1_address_o", LW'(address_o), LW'(32'h0000_1220));
        check("t1_line_o", line_o, exp1);

        // Write with memory always accepting.
        wl = {64'hDEAD_0003_0000_BEEF, 64'hDEAD_0002_0000_BEEF,
              64'hDEAD_0001_0000_BEEF, 64'hDEAD_0000_0000_BEEF};
        run_txn(1'b0, 1'b1, 32'h0000_5678, wl, bt, 6);
        check("t2_line_o_hold", line_o, exp1);

        // Read with gaps: beats accepted on burst cycles 0,3,4,7.
        for (int i = 0; i < BEATS; i++) bt[i] = {$urandom, $urandom};
        use_pattern  = 1'b1;
        resp_pattern = 32'h0000_0099;
        run_txn(1'b1, 1'b0, 32'h0000_9ABC, '0, bt, 10);
        use_pattern  = 1'b0;

        // Reset after two beats of a read; then a fresh read.
        @(negedge clk);
        for (int i = 0; i < BEATS; i++) mem_q.push_back(64'hBAD0_0000_0000_0000 | 64'(i));
        cur_addr  = 32'h0000_0040;
        read_i    = 1'b1;
        address_i = 32'h0000_0040;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_read_o", LW'(read_o), '0);
        check("abort_resp_o", LW'(resp_o), '0);
        read_i = 1'b0;
        exp_q.delete();
        mem_q.delete();
        wr_q.delete();
        model_reads  = 0;
        model_writes = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < BEATS; i++) bt[i] = {$urandom, $urandom};
        run_txn(1'b1, 1'b0, 32'h0000_0040, '0, bt, 6);

        // Read and write together: the read must win.
        for (int i = 0; i < BEATS; i++) bt[i] = {$urandom, $urandom};
        for (int i = 0; i < 8; i++) wl[i*32 +: 32] = $urandom;
        run_txn(1'b1, 1'b1, 32'h0000_7F00, wl, bt, 6);

        // Random mix with random memory gaps.
        gap_pct = 30;
        for (int n = 0; n < 24; n++) begin
            rd_sel = 1'($urandom_range(1));
            for (int i = 0; i < BEATS; i++) bt[i] = {$urandom, $urandom};
            for (int i = 0; i < 8; i++) wl[i*32 +: 32] = $urandom;
            run_txn(rd_sel, !rd_sel, $urandom, wl, bt, 0);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", LW'(exp_q.size()), '0);
`ifdef ADAPTOR_PERF_CNT_EN
        check("perf_reads", LW'(perf_reads), LW'(model_reads));
        check("perf_writes", LW'(perf_writes), LW'(model_writes));
`else
        check("perf_reads", LW'(perf_reads), '0);
        check("perf_writes", LW'(perf_writes), '0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
